// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci sequencer: state encodings, default widths
// and the ins/modes encodings agreed with the count ALU.
package fib_pkg;

  localparam int N_W_DEF = 3;
  localparam int R_W_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic INS_LOAD  = 1'b1;
  localparam logic INS_DEC   = 1'b0;
  localparam logic MODES_CMP = 1'b1;
  localparam logic MODES_OFF = 1'b0;

endpackage

// File: rtl/fib_acc.sv
// Fibonacci accumulator pair (a, b): init loads (0,1), step advances one term.
// FIB_OVF_EN adds saturating b with overflow flags that follow b into a.
module fib_acc
  import fib_pkg::*;
#(
  parameter int R_W = R_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_init,
  input  logic           i_step,
  output logic [R_W-1:0] o_a
`ifdef FIB_OVF_EN
  ,
  output logic           o_a_ovf
`endif
);

  logic [R_W-1:0] r_a;
  logic [R_W-1:0] r_b;

`ifdef FIB_OVF_EN
  logic [R_W:0] w_sum;
  logic         w_b_sat;
  logic         r_a_ovf;
  logic         r_b_ovf;

  assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
  // Once b has saturated it stays pinned at all ones.
  assign w_b_sat = w_sum[R_W] | r_b_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_a_ovf <= 1'b0;
      r_b_ovf <= 1'b0;
    end else if (i_init) begin
      r_a     <= '0;
      r_b     <= {{(R_W-1){1'b0}}, 1'b1};
      r_a_ovf <= 1'b0;
      r_b_ovf <= 1'b0;
    end else if (i_step) begin
      r_a     <= r_b;
      r_b     <= w_b_sat ? {R_W{1'b1}} : w_sum[R_W-1:0];
      r_a_ovf <= r_b_ovf;
      r_b_ovf <= w_b_sat;
    end
  end

  assign o_a_ovf = r_a_ovf;
`else
  logic [R_W-1:0] w_sum;

  assign w_sum = r_a + r_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
    end else if (i_init) begin
      r_a <= '0;
      r_b <= {{(R_W-1){1'b0}}, 1'b1};
    end else if (i_step) begin
      r_a <= r_b;
      r_b <= w_sum;
    end
  end
`endif

  assign o_a = r_a;

endmodule

// File: rtl/fib_seq_ctrl.sv
// Fibonacci sequencer driving the count ALU; F(n) with a done pulse n+3 cycles after accept,
// start is ignored while busy (no queueing). FIB_OVF_EN enables saturation and the sticky ovf port.
module fib_seq_ctrl
  import fib_pkg::*;
#(
  parameter int N_W = N_W_DEF,
  parameter int R_W = R_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] n,
  output logic           busy,
  output logic           done,
  output logic [R_W-1:0] result,
`ifdef FIB_OVF_EN
  output logic           ovf,
`endif
  output logic [N_W-1:0] alu_n,
  output logic [N_W-1:0] alu_ts,
  output logic           alu_ins,
  output logic           alu_modes,
  input  logic [N_W-1:0] alu_dec,
  input  logic           alu_lt
);

  state_t         r_state;
  logic [N_W-1:0] r_n_q;
  logic [N_W-1:0] r_ts;
  logic           r_busy;
  logic           r_done;
  logic [R_W-1:0] r_result;
  logic           r_ins;
  logic           r_modes;
  logic [R_W-1:0] w_a;
  logic           w_init;
  logic           w_step;

  assign w_init = (r_state == S_LOAD);
  assign w_step = (r_state == S_RUN) && !alu_lt;

`ifdef FIB_OVF_EN
  logic w_a_ovf;
  logic r_ovf;

  fib_acc #(.R_W(R_W)) u_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_init  (w_init),
    .i_step  (w_step),
    .o_a     (w_a),
    .o_a_ovf (w_a_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_ovf <= 1'b0;
    end else if (r_state == S_RUN && alu_lt) begin
      r_ovf <= r_ovf | w_a_ovf;
    end
  end

  assign ovf = r_ovf;
`else
  fib_acc #(.R_W(R_W)) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_init (w_init),
    .i_step (w_step),
    .o_a    (w_a)
  );
`endif

  // ts only ever takes the ALU's answer: load of n_q in LOAD, ts-1 in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_n_q    <= '0;
      r_ts     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_ins    <= INS_DEC;
      r_modes  <= MODES_OFF;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_n_q   <= n;
            r_busy  <= 1'b1;
            r_ins   <= INS_LOAD;
            r_modes <= MODES_OFF;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_ts    <= alu_dec;
          r_ins   <= INS_DEC;
          r_modes <= MODES_CMP;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (alu_lt) begin
            r_result <= w_a;
            r_done   <= 1'b1;
            r_modes  <= MODES_OFF;
            r_state  <= S_DONE;
          end else begin
            r_ts <= alu_dec;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign alu_n     = r_n_q;
  assign alu_ts    = r_ts;
  assign alu_ins   = r_ins;
  assign alu_modes = r_modes;

endmodule
